wbxbc_req_slice: RTL and testbench

- Pipelined Wishbone request register slice, placed directly upstream of a crossbar pass-through stage.
- Breaks the combinational stall path from target to initiator and registers all initiator-to-target request signals through a 2-entry skid buffer.
- Termination responses and read data pass back combinationally, gated by itr_cyc_i.
- Full throughput of one request per clock when the target does not stall; request latency is 1 cycle.

---
 rtl/wbxbc_pkg.sv | 34 +++
 rtl/wbxbc_skid_buf.sv | 65 ++++++
 rtl/wbxbc_req_slice.sv | 96 +++++++++
 tb/tb_wbxbc_req_slice.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/wbxbc_pkg.sv
// Shared constants and the request-entry layout for the Wishbone request slice.
// The struct shows the default-width layout; entry_width() sizes the flat vector.
package wbxbc_pkg;

  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_EMPTY = 2'd0;
  localparam logic [CNT_W-1:0] CNT_ONE   = 2'd1;
  localparam logic [CNT_W-1:0] CNT_FULL  = 2'd2;

  localparam int DEF_ADR_WIDTH  = 16;
  localparam int DEF_DAT_WIDTH  = 16;
  localparam int DEF_SEL_WIDTH  = 2;
  localparam int DEF_TGA_WIDTH  = 1;
  localparam int DEF_TGC_WIDTH  = 1;
  localparam int DEF_TGWD_WIDTH = 1;

  typedef struct packed {
    logic                      we;
    logic                      lock;
    logic [DEF_SEL_WIDTH-1:0]  sel;
    logic [DEF_ADR_WIDTH-1:0]  adr;
    logic [DEF_DAT_WIDTH-1:0]  dat;
    logic [DEF_TGA_WIDTH-1:0]  tga;
    logic [DEF_TGC_WIDTH-1:0]  tgc;
    logic [DEF_TGWD_WIDTH-1:0] tgd;
  } req_entry_t;

  // Same field order as req_entry_t, for arbitrary widths.
  function automatic int entry_width(input int adr_w, input int dat_w, input int sel_w,
                                     input int tga_w, input int tgc_w, input int tgd_w);
    return 2 + sel_w + adr_w + dat_w + tga_w + tgc_w + tgd_w;
  endfunction

endpackage

// File: rtl/wbxbc_skid_buf.sv
// Generic 2-entry synchronous FIFO: push/pop/flush, occupancy count, head and full.
// Head is read straight from the entry at the read pointer so it is valid the cycle after a push.
module wbxbc_skid_buf
  import wbxbc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             sync_rst_n_i,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             rd_ptr_reg;
  logic             wr_ptr_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CNT_FULL);
  assign push_ok = push & ~full & sync_rst_n_i & ~flush;
  assign pop_ok  = pop & (count_reg != CNT_EMPTY) & sync_rst_n_i & ~flush;

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  // Flush shares the reset path so it overrides any push or pop in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!sync_rst_n_i || flush) begin
      count_reg  <= CNT_EMPTY;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (push_ok) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop_ok)  rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [WIDTH-1:0] data_reg;
      always_ff @(posedge clk_i) begin
        if (push_ok && (wr_ptr_reg == 1'(gi))) data_reg <= wr_data;
      end
    end
  endgenerate

  assign head  = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;
  assign count = count_reg;

endmodule

// File: rtl/wbxbc_req_slice.sv
// Pipelined Wishbone request register slice: requests go through a 2-entry skid buffer,
// responses and read data pass back combinationally. Stall to the initiator is flop-driven only.
module wbxbc_req_slice
  import wbxbc_pkg::*;
#(
  parameter int ADR_WIDTH  = 16,
  parameter int DAT_WIDTH  = 16,
  parameter int SEL_WIDTH  = 2,
  parameter int TGA_WIDTH  = 1,
  parameter int TGC_WIDTH  = 1,
  parameter int TGRD_WIDTH = 1,
  parameter int TGWD_WIDTH = 1
) (
  input  logic                  clk_i,
  input  logic                  sync_rst_n_i,
  input  logic                  itr_cyc_i,
  input  logic                  itr_stb_i,
  input  logic                  itr_we_i,
  input  logic                  itr_lock_i,
  input  logic [SEL_WIDTH-1:0]  itr_sel_i,
  input  logic [ADR_WIDTH-1:0]  itr_adr_i,
  input  logic [DAT_WIDTH-1:0]  itr_dat_i,
  input  logic [TGA_WIDTH-1:0]  itr_tga_i,
  input  logic [TGC_WIDTH-1:0]  itr_tgc_i,
  input  logic [TGWD_WIDTH-1:0] itr_tgd_i,
  output logic                  itr_ack_o,
  output logic                  itr_err_o,
  output logic                  itr_rty_o,
  output logic                  itr_stall_o,
  output logic [DAT_WIDTH-1:0]  itr_dat_o,
  output logic [TGRD_WIDTH-1:0] itr_tgd_o,
  output logic                  tgt_cyc_o,
  output logic                  tgt_stb_o,
  output logic                  tgt_we_o,
  output logic                  tgt_lock_o,
  output logic [SEL_WIDTH-1:0]  tgt_sel_o,
  output logic [ADR_WIDTH-1:0]  tgt_adr_o,
  output logic [DAT_WIDTH-1:0]  tgt_dat_o,
  output logic [TGA_WIDTH-1:0]  tgt_tga_o,
  output logic [TGC_WIDTH-1:0]  tgt_tgc_o,
  output logic [TGWD_WIDTH-1:0] tgt_tgd_o,
  input  logic                  tgt_ack_i,
  input  logic                  tgt_err_i,
  input  logic                  tgt_rty_i,
  input  logic                  tgt_stall_i,
  input  logic [DAT_WIDTH-1:0]  tgt_dat_i,
  input  logic [TGRD_WIDTH-1:0] tgt_tgd_i
);

  localparam int ENTRY_W = entry_width(ADR_WIDTH, DAT_WIDTH, SEL_WIDTH,
                                       TGA_WIDTH, TGC_WIDTH, TGWD_WIDTH);

  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               head_lock;
  logic               push;
  logic               pop;

  assign wr_entry = {itr_we_i, itr_lock_i, itr_sel_i, itr_adr_i,
                     itr_dat_i, itr_tga_i, itr_tgc_i, itr_tgd_i};

  assign itr_stall_o = full | ~sync_rst_n_i;
  assign push        = itr_cyc_i & itr_stb_i & ~itr_stall_o & sync_rst_n_i;
  assign tgt_cyc_o   = itr_cyc_i;
  assign tgt_stb_o   = itr_cyc_i & (count != CNT_EMPTY);
  assign pop         = tgt_stb_o & ~tgt_stall_i;

  wbxbc_skid_buf #(
    .WIDTH (ENTRY_W)
  ) u_skid_buf (
    .clk_i        (clk_i),
    .sync_rst_n_i (sync_rst_n_i),
    .push         (push),
    .pop          (pop),
    .flush        (~itr_cyc_i),
    .wr_data      (wr_entry),
    .head         (head_entry),
    .count        (count),
    .full         (full)
  );

  assign {tgt_we_o, head_lock, tgt_sel_o, tgt_adr_o,
          tgt_dat_o, tgt_tga_o, tgt_tgc_o, tgt_tgd_o} = head_entry;

  // With nothing buffered, lock tracks the initiator so a locked cycle never glitches low.
  assign tgt_lock_o = (count == CNT_EMPTY) ? itr_lock_i : head_lock;

  assign itr_ack_o = tgt_ack_i & itr_cyc_i;
  assign itr_err_o = tgt_err_i & itr_cyc_i;
  assign itr_rty_o = tgt_rty_i & itr_cyc_i;
  assign itr_dat_o = tgt_dat_i;
  assign itr_tgd_o = tgt_tgd_i;

endmodule

// File: tb/tb_wbxbc_req_slice.sv
// Directed bench for wbxbc_req_slice: inputs change 1 ns after each rising edge,
// outputs are checked 1 ns later with hand-computed expectations.
module tb_wbxbc_req_slice;

  logic        clk_i = 1'b0;
  logic        sync_rst_n_i;
  logic        itr_cyc_i, itr_stb_i, itr_we_i, itr_lock_i;
  logic [1:0]  itr_sel_i;
  logic [15:0] itr_adr_i, itr_dat_i;
  logic [0:0]  itr_tga_i, itr_tgc_i, itr_tgd_i;
  logic        itr_ack_o, itr_err_o, itr_rty_o, itr_stall_o;
  logic [15:0] itr_dat_o;
  logic [0:0]  itr_tgd_o;
  logic        tgt_cyc_o, tgt_stb_o, tgt_we_o, tgt_lock_o;
  logic [1:0]  tgt_sel_o;
  logic [15:0] tgt_adr_o, tgt_dat_o;
  logic [0:0]  tgt_tga_o, tgt_tgc_o, tgt_tgd_o;
  logic        tgt_ack_i, tgt_err_i, tgt_rty_i, tgt_stall_i;
  logic [15:0] tgt_dat_i;
  logic [0:0]  tgt_tgd_i;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk_i = ~clk_i;

  wbxbc_req_slice dut (
    .clk_i(clk_i), .sync_rst_n_i(sync_rst_n_i),
    .itr_cyc_i(itr_cyc_i), .itr_stb_i(itr_stb_i), .itr_we_i(itr_we_i), .itr_lock_i(itr_lock_i),
    .itr_sel_i(itr_sel_i), .itr_adr_i(itr_adr_i), .itr_dat_i(itr_dat_i),
    .itr_tga_i(itr_tga_i), .itr_tgc_i(itr_tgc_i), .itr_tgd_i(itr_tgd_i),
    .itr_ack_o(itr_ack_o), .itr_err_o(itr_err_o), .itr_rty_o(itr_rty_o), .itr_stall_o(itr_stall_o),
    .itr_dat_o(itr_dat_o), .itr_tgd_o(itr_tgd_o),
    .tgt_cyc_o(tgt_cyc_o), .tgt_stb_o(tgt_stb_o), .tgt_we_o(tgt_we_o), .tgt_lock_o(tgt_lock_o),
    .tgt_sel_o(tgt_sel_o), .tgt_adr_o(tgt_adr_o), .tgt_dat_o(tgt_dat_o),
    .tgt_tga_o(tgt_tga_o), .tgt_tgc_o(tgt_tgc_o), .tgt_tgd_o(tgt_tgd_o),
    .tgt_ack_i(tgt_ack_i), .tgt_err_i(tgt_err_i), .tgt_rty_i(tgt_rty_i), .tgt_stall_i(tgt_stall_i),
    .tgt_dat_i(tgt_dat_i), .tgt_tgd_i(tgt_tgd_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic req(input logic stb, input logic we, input logic [15:0] adr, input logic [15:0] dat);
    itr_stb_i = stb;
    itr_we_i  = we;
    itr_adr_i = adr;
    itr_dat_i = dat;
  endtask

  // Stalled 4-read burst: target stall held for cycles 1..3.
  logic       t2_stb   [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
  logic [15:0] t2_adr  [9] = '{16'h20, 16'h21, 16'h22, 16'h22, 16'h22, 16'h22, 16'h23, 16'h0, 16'h0};
  logic       t2_tst   [9] = '{0, 1, 1, 1, 0, 0, 0, 0, 0};
  logic       t2_xstb  [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
  logic [15:0] t2_xadr [9] = '{16'h0, 16'h20, 16'h20, 16'h20, 16'h20, 16'h21, 16'h22, 16'h23, 16'h0};
  logic       t2_xstl  [9] = '{0, 0, 1, 1, 1, 0, 0, 0, 0};

  initial begin
    sync_rst_n_i = 1'b0;
    itr_cyc_i = 1'b1; itr_lock_i = 1'b0; itr_sel_i = 2'b11;
    itr_tga_i = 1'b1; itr_tgc_i = 1'b0; itr_tgd_i = 1'b1;
    req(1'b1, 1'b1, 16'hDEAD, 16'h0);
    tgt_ack_i = 1'b0; tgt_err_i = 1'b0; tgt_rty_i = 1'b0; tgt_stall_i = 1'b0;
    tgt_dat_i = 16'h0; tgt_tgd_i = 1'b0;

    // Reset with a request presented: nothing may be captured.
    next_cycle(); settle();
    check_eq("rst_stall", 32'(itr_stall_o), 32'd1);
    next_cycle(); settle();
    check_eq("rst_stall2", 32'(itr_stall_o), 32'd1);
    check_eq("rst_stb", 32'(tgt_stb_o), 32'd0);
    sync_rst_n_i = 1'b1;
    req(1'b0, 1'b0, 16'h0, 16'h0);
    settle();
    check_eq("post_rst_stall", 32'(itr_stall_o), 32'd0);
    check_eq("post_rst_stb", 32'(tgt_stb_o), 32'd0);

    // Back-to-back writes 0x10..0x13, target never stalls.
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      if (i < 4) req(1'b1, 1'b1, 16'h0010 + 16'(i), 16'hA000 + 16'(i));
      else       req(1'b0, 1'b0, 16'h0, 16'h0);
      settle();
      check_eq($sformatf("b2b_stall[%0d]", i), 32'(itr_stall_o), 32'd0);
      if (i >= 1 && i <= 4) begin
        check_eq($sformatf("b2b_stb[%0d]", i), 32'(tgt_stb_o), 32'd1);
        check_eq($sformatf("b2b_adr[%0d]", i), 32'(tgt_adr_o), 32'h10 + 32'(i - 1));
        check_eq($sformatf("b2b_dat[%0d]", i), 32'(tgt_dat_o), 32'hA000 + 32'(i - 1));
        check_eq($sformatf("b2b_we[%0d]", i), 32'(tgt_we_o), 32'd1);
      end else begin
        check_eq($sformatf("b2b_stb[%0d]", i), 32'(tgt_stb_o), 32'd0);
      end
    end
    check_eq("tags", {26'd0, tgt_sel_o, tgt_tga_o, tgt_tgc_o, tgt_tgd_o, tgt_cyc_o}, 32'b11_1_0_1_1);

    // Read burst with target stall; fields must hold while stalled.
    for (int i = 0; i < 9; i++) begin
      next_cycle();
      req(t2_stb[i], 1'b0, t2_adr[i], 16'h0);
      tgt_stall_i = t2_tst[i];
      settle();
      check_eq($sformatf("stl_stall[%0d]", i), 32'(itr_stall_o), 32'(t2_xstl[i]));
      check_eq($sformatf("stl_stb[%0d]", i), 32'(tgt_stb_o), 32'(t2_xstb[i]));
      if (t2_xstb[i]) begin
        check_eq($sformatf("stl_adr[%0d]", i), 32'(tgt_adr_o), 32'(t2_xadr[i]));
        check_eq($sformatf("stl_we[%0d]", i), 32'(tgt_we_o), 32'd0);
      end
    end

    // Push and pop together at count 1 for 10 cycles; pointers wrap repeatedly.
    for (int i = 0; i < 13; i++) begin
      next_cycle();
      if (i < 11) req(1'b1, 1'b1, 16'h0030 + 16'(i), 16'h0);
      else        req(1'b0, 1'b0, 16'h0, 16'h0);
      settle();
      check_eq($sformatf("pp_stall[%0d]", i), 32'(itr_stall_o), 32'd0);
      if (i >= 1 && i <= 11) begin
        check_eq($sformatf("pp_stb[%0d]", i), 32'(tgt_stb_o), 32'd1);
        check_eq($sformatf("pp_adr[%0d]", i), 32'(tgt_adr_o), 32'h30 + 32'(i - 1));
      end else begin
        check_eq($sformatf("pp_stb[%0d]", i), 32'(tgt_stb_o), 32'd0);
      end
    end

    // Abort with the buffer full.
    next_cycle(); req(1'b1, 1'b0, 16'h0050, 16'h0); tgt_stall_i = 1'b1;
    next_cycle(); req(1'b1, 1'b0, 16'h0051, 16'h0);
    next_cycle(); req(1'b0, 1'b0, 16'h0, 16'h0); itr_cyc_i = 1'b0; settle();
    check_eq("abort_stb", 32'(tgt_stb_o), 32'd0);
    check_eq("abort_cyc", 32'(tgt_cyc_o), 32'd0);
    check_eq("abort_stall", 32'(itr_stall_o), 32'd1);
    next_cycle(); itr_cyc_i = 1'b1; tgt_stall_i = 1'b0; req(1'b1, 1'b0, 16'h0040, 16'h0); settle();
    check_eq("abort_empty_stb", 32'(tgt_stb_o), 32'd0);
    check_eq("abort_empty_stall", 32'(itr_stall_o), 32'd0);
    next_cycle(); req(1'b0, 1'b0, 16'h0, 16'h0); settle();
    check_eq("abort_new_stb", 32'(tgt_stb_o), 32'd1);
    check_eq("abort_new_adr", 32'(tgt_adr_o), 32'h40);
    next_cycle(); settle();
    check_eq("abort_done_stb", 32'(tgt_stb_o), 32'd0);

    // Reset for one cycle with the buffer full.
    next_cycle(); req(1'b1, 1'b0, 16'h0060, 16'h0); tgt_stall_i = 1'b1;
    next_cycle(); req(1'b1, 1'b0, 16'h0061, 16'h0);
    next_cycle(); req(1'b1, 1'b0, 16'h0062, 16'h0); sync_rst_n_i = 1'b0; settle();
    check_eq("mrst_stall", 32'(itr_stall_o), 32'd1);
    next_cycle(); sync_rst_n_i = 1'b1; req(1'b0, 1'b0, 16'h0, 16'h0); tgt_stall_i = 1'b0; settle();
    check_eq("mrst_stb", 32'(tgt_stb_o), 32'd0);
    check_eq("mrst_stall_after", 32'(itr_stall_o), 32'd0);

    // Response gating and combinational read data.
    next_cycle(); tgt_err_i = 1'b1; settle();
    check_eq("err_gated_on", 32'(itr_err_o), 32'd1);
    next_cycle(); itr_cyc_i = 1'b0; settle();
    check_eq("err_gated_off", 32'(itr_err_o), 32'd0);
    next_cycle(); itr_cyc_i = 1'b1; tgt_err_i = 1'b0; tgt_ack_i = 1'b1;
    tgt_dat_i = 16'hBEEF; tgt_tgd_i = 1'b1; settle();
    check_eq("ack_on", 32'(itr_ack_o), 32'd1);
    check_eq("rd_dat", 32'(itr_dat_o), 32'hBEEF);
    check_eq("rd_tgd", 32'(itr_tgd_o), 32'd1);
    check_eq("err_idle", 32'(itr_err_o), 32'd0);
    next_cycle(); tgt_ack_i = 1'b0; tgt_rty_i = 1'b1; settle();
    check_eq("rty_on", 32'(itr_rty_o), 32'd1);
    check_eq("ack_off", 32'(itr_ack_o), 32'd0);
    next_cycle(); itr_cyc_i = 1'b0; settle();
    check_eq("rty_gated_off", 32'(itr_rty_o), 32'd0);

    // Lock follows the initiator when empty, the head entry otherwise.
    next_cycle(); itr_cyc_i = 1'b1; tgt_rty_i = 1'b0; itr_lock_i = 1'b1; settle();
    check_eq("lock_empty", 32'(tgt_lock_o), 32'd1);
    next_cycle(); req(1'b1, 1'b0, 16'h0070, 16'h0); tgt_stall_i = 1'b1;
    next_cycle(); req(1'b0, 1'b0, 16'h0, 16'h0); itr_lock_i = 1'b0; tgt_stall_i = 1'b0; settle();
    check_eq("lock_head", 32'(tgt_lock_o), 32'd1);
    check_eq("lock_adr", 32'(tgt_adr_o), 32'h70);
    next_cycle(); settle();
    check_eq("lock_follow", 32'(tgt_lock_o), 32'd0);

    itr_cyc_i = 1'b0;
    next_cycle();
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
